if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL give the PC value loaded on reset.
REQ-002 clk  input  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 freeze  input  1  SHALL mean the downstream stage register holds and does not consume the current output.
REQ-005 branch_taken  input  1  SHALL mean a single-cycle redirect request from EXE.
REQ-006 branch_addr  input  32  SHALL give the redirect target, sampled only when branch_taken=1.
REQ-007 mem_req  output  1  SHALL be the registered instruction-memory request.
REQ-008 mem_addr  output  32  SHALL be the registered fetch address, word-aligned.
REQ-009 mem_ack  input  1  SHALL mean the request completed this cycle; mem_rdata is valid.
REQ-010 mem_rdata  input  32  SHALL be the instruction word returned with mem_ack.
REQ-011 pc_out  output  32  SHALL be the fetch address of the head instruction plus 4.
REQ-012 instruction_out  output  32  SHALL be the head instruction word.
REQ-013 fetch_valid  output  1  SHALL mean pc_out/instruction_out hold an unconsumed instruction.

Function
REQ-014 The block SHALL hold PC register pc, a 2-entry FIFO of {addr+4, instr}, count 0..2, and FSM state in {IDLE, REQ, DISCARD}.
REQ-015 Outputs: fetch_valid = (count>0); pc_out/instruction_out SHALL equal the FIFO head, or 0 when count=0.
REQ-016 pop = fetch_valid & ~freeze & ~branch_taken; pop SHALL remove the head in that cycle.
REQ-017 push = (state==REQ) & mem_ack & ~branch_taken; push SHALL write {mem_addr+4, mem_rdata} to the tail.
REQ-018 next_count = count + push - pop; count SHALL never exceed 2 or underflow.
REQ-019 mem_req SHALL be 1 exactly in states REQ and DISCARD, and mem_req and mem_addr SHALL stay stable until mem_ack.
REQ-020 IDLE -> REQ when ~branch_taken and next_count<2: mem_req<=1, mem_addr<=pc.
REQ-021 REQ & mem_ack & ~branch_taken: pc<=mem_addr+4; stay REQ with mem_addr<=mem_addr+4 if next_count<2, else -> IDLE with mem_req<=0.
REQ-022 Throughput SHALL be one instruction per cycle with zero-wait memory, where mem_ack arrives in the first cycle mem_req=1.
REQ-023 branch_taken SHALL have priority over freeze, push and pop: pc<=branch_addr, count<=0 next cycle.
REQ-024 branch_taken in IDLE, or in REQ with mem_ack: response dropped, -> REQ with mem_addr<=branch_addr.
REQ-025 branch_taken in REQ without mem_ack: -> DISCARD, and mem_req/mem_addr SHALL hold the old request.
REQ-026 DISCARD & mem_ack: mem_rdata dropped, -> REQ with mem_addr<=pc, and no push.
REQ-027 branch_taken in DISCARD SHALL update pc to the new branch_addr and stay DISCARD; only the final target SHALL be fetched.
REQ-028 mem_ack while state IDLE SHALL be ignored.
REQ-029 pc and mem_addr SHALL wrap modulo 2^32, and bits [1:0] SHALL always be 0.

Reset
REQ-030 While rst=1: pc=RESET_PC, state=IDLE, count=0, mem_req=0, mem_addr=0, fetch_valid=0, pc_out=0, instruction_out=0.
REQ-031 Reset asserted mid-request SHALL abandon it immediately, and a late mem_ack after release SHALL be ignored while IDLE.
REQ-032 First request SHALL issue on the first clock edge after rst falls, with mem_addr=RESET_PC, and mem_req seen 1 in the following cycle.

Verification
REQ-033 Zero-wait memory, freeze=0: mem_addr 0,4,8,...; pc_out 4,8,12,... one per cycle after first fill; no gaps.
REQ-034 freeze=1 for 6 cycles: count reaches 2, mem_req drops to 0, outputs constant; freeze=0 gives the next pc_out +4, with no lost or duplicate instructions.
REQ-035 Ack delayed 3 cycles, branch_taken to 0x100 during the wait: old data dropped, next mem_addr=0x100, fetch_valid=0 until its ack, then pc_out=0x104.
REQ-036 branch_taken to 0x200 in the same cycle as mem_ack: data dropped, next cycle mem_addr=0x200, count=0.
REQ-037 FIFO full with freeze=1, then branch_taken to 0x40: count=0 next cycle, fetch resumes at 0x40 despite freeze.
REQ-038 rst pulsed while mem_req=1 at 0x1C: mem_req=0 and all outputs 0 immediately; after release, mem_addr=RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues word-aligned requests to instruction memory,
// buffers up to two returned instructions in a small FIFO, and redirects on a
// branch from EXE. Responses belonging to a request made before a redirect are
// dropped so that only the branch target stream reaches the decode stage.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        fetch_valid
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;

    // FIFO storage: head is the entry presented downstream, tail the second one.
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] head_ins_q, head_ins_d;
    logic [31:0] tail_pc_q, tail_pc_d;
    logic [31:0] tail_ins_q, tail_ins_d;

    logic        pop;
    logic        push;
    logic [1:0]  next_count;
    logic [1:0]  remaining;
    logic [31:0] br_target;
    logic [31:0] seq_addr;

    // Redirect targets are forced onto a word boundary; the sequential address
    // wraps naturally in 32-bit arithmetic.
    assign br_target  = {branch_addr[31:2], 2'b00};
    assign seq_addr   = mem_addr_q + 32'd4;

    assign fetch_valid = (count_q != 2'd0);
    assign pop         = fetch_valid & ~freeze & ~branch_taken;
    assign push        = (state_q == S_REQ) & mem_ack & ~branch_taken;
    assign next_count  = count_q + {1'b0, push} - {1'b0, pop};
    assign remaining   = count_q - {1'b0, pop};

    assign mem_req         = mem_req_q;
    assign mem_addr        = mem_addr_q;
    assign pc_out          = fetch_valid ? head_pc_q  : 32'd0;
    assign instruction_out = fetch_valid ? head_ins_q : 32'd0;

    // Request FSM, PC and occupancy next-state; a branch overrides everything.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        count_d    = branch_taken ? 2'd0 : next_count;
        if (branch_taken) begin
            pc_d = br_target;
            case (state_q)
                S_IDLE: begin
                    state_d    = S_REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = br_target;
                end
                S_REQ: begin
                    // With an ack the bus is free to take the target at once;
                    // otherwise the outstanding request must be held and drained.
                    if (mem_ack) begin
                        mem_addr_d = br_target;
                    end else begin
                        state_d = S_DISCARD;
                    end
                end
                default: begin
                    // Keep draining the stale request; pc now holds the latest target.
                    state_d = S_DISCARD;
                end
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (next_count < 2'd2) begin
                        state_d    = S_REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_q;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        pc_d = seq_addr;
                        if (next_count < 2'd2) begin
                            mem_addr_d = seq_addr;
                        end else begin
                            state_d   = S_IDLE;
                            mem_req_d = 1'b0;
                        end
                    end
                end
                default: begin
                    if (mem_ack) begin
                        state_d    = S_REQ;
                        mem_addr_d = pc_q;
                    end
                end
            endcase
        end
    end

    // FIFO data next-state: shift the tail forward on pop, write at the first free slot on push.
    always_comb begin
        head_pc_d  = head_pc_q;
        head_ins_d = head_ins_q;
        tail_pc_d  = tail_pc_q;
        tail_ins_d = tail_ins_q;
        if (pop && (count_q == 2'd2)) begin
            head_pc_d  = tail_pc_q;
            head_ins_d = tail_ins_q;
        end
        if (push) begin
            if (remaining == 2'd0) begin
                head_pc_d  = seq_addr;
                head_ins_d = mem_rdata;
            end else begin
                tail_pc_d  = seq_addr;
                tail_ins_d = mem_rdata;
            end
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= {RESET_PC[31:2], 2'b00};
            count_q    <= 2'd0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // FIFO payload; contents are qualified by count so no reset is needed.
    always_ff @(posedge clk) begin
        head_pc_q  <= head_pc_d;
        head_ins_q <= head_ins_d;
        tail_pc_q  <= tail_pc_d;
        tail_ins_q <= tail_ins_d;
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed scenarios plus a randomized run whose
// consumed instruction stream is checked against the architectural rule that
// after reset or a redirect to T the instructions delivered are T, T+4, ...
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        fetch_valid;

    int checks = 0;
    int errors = 0;

    // Memory model controls: 0 zero-wait, 1 fixed latency, 2 random, 3 never.
    int   ack_mode;
    int   lat;
    int   wait_cnt;
    int   proto_bad;
    logic ack_force;

    typedef struct {
        logic        br;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;
    ev_t log_q[$];

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_addr     (branch_addr),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .fetch_valid     (fetch_valid)
    );

    // Instruction memory contents: a bijection of the address.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: memory response, consumption/redirect log, protocol watch.
    task automatic tick();
        logic        p_req;
        logic        p_ack;
        logic [31:0] p_addr;
        case (ack_mode)
            0:       mem_ack = mem_req;
            1:       mem_ack = mem_req && (wait_cnt >= lat);
            2:       mem_ack = mem_req && ($urandom_range(0, 1) == 1);
            default: mem_ack = 1'b0;
        endcase
        if (ack_force) mem_ack = 1'b1;
        mem_rdata = (mem_ack && mem_req) ? memfn(mem_addr) : $urandom();
        #1;
        p_req  = mem_req;
        p_ack  = mem_ack;
        p_addr = mem_addr;
        if (!rst && fetch_valid && !freeze && !branch_taken)
            log_q.push_back('{1'b0, pc_out, instruction_out});
        if (!rst && branch_taken)
            log_q.push_back('{1'b1, branch_addr, 32'd0});
        @(posedge clk);
        #1;
        if (p_req && !p_ack) wait_cnt++;
        else wait_cnt = 0;
        if (!rst && p_req && !p_ack && (!mem_req || mem_addr !== p_addr)) proto_bad++;
        if (mem_addr[1:0] !== 2'b00) proto_bad++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0;
        ack_force = 1'b0; ack_mode = 0; lat = 0;
        tick();
        tick();
        rst = 1'b0;
        wait_cnt = 0;
        log_q.delete();
    endtask

    // Reset, one request cycle, then n zero-wait cycles: head pc_out = 4n.
    task automatic warm(input int n);
        apply_reset();
        tick();
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0;
        ack_force = 1'b0; ack_mode = 0; lat = 0; wait_cnt = 0;
        tick();
        tick();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", fetch_valid); end
        checks++; if (pc_out !== 32'd0) begin errors++; $display("FAIL reset_pc_out: got %h want 0", pc_out); end
        checks++; if (instruction_out !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h want 0", instruction_out); end
        rst = 1'b0;
        tick();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", mem_req); end
        checks++; if (mem_addr !== RST_PC) begin errors++; $display("FAIL first_addr: got %h want %h", mem_addr, RST_PC); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL first_valid: got %b want 0", fetch_valid); end
    endtask

    task automatic test_stream();
        warm(0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", i, fetch_valid); end
            checks++; if (pc_out !== 32'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", i, pc_out, 32'(4 * i)); end
            checks++; if (instruction_out !== memfn(32'(4 * (i - 1)))) begin errors++; $display("FAIL stream_instr[%0d]: got %h want %h", i, instruction_out, memfn(32'(4 * (i - 1)))); end
            checks++; if (mem_addr !== 32'(4 * i)) begin errors++; $display("FAIL stream_addr[%0d]: got %h want %h", i, mem_addr, 32'(4 * i)); end
        end
    endtask

    task automatic test_freeze();
        warm(4);
        freeze = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (pc_out !== 32'd16 || instruction_out !== memfn(32'd12)) begin errors++; $display("FAIL freeze_hold[%0d]: got %h/%h want 10/%h", i, pc_out, instruction_out, memfn(32'd12)); end
        end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL freeze_req_drop: got %b want 0", mem_req); end
        checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL freeze_valid: got %b want 1", fetch_valid); end
        freeze = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (pc_out !== 32'(20 + 4 * i) || instruction_out !== memfn(32'(16 + 4 * i))) begin errors++; $display("FAIL unfreeze_seq[%0d]: got %h/%h want %h/%h", i, pc_out, instruction_out, 32'(20 + 4 * i), memfn(32'(16 + 4 * i))); end
        end
    endtask

    task automatic test_delayed_branch();
        warm(2);
        ack_mode = 1; lat = 3;
        tick();
        branch_taken = 1'b1; branch_addr = 32'h100;
        tick();
        branch_taken = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd8) begin errors++; $display("FAIL discard_hold: got %b/%h want 1/8", mem_req, mem_addr); end
        tick();
        tick();
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL discard_next_addr: got %h want 100", mem_addr); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL discard_dropped: got %b want 0", fetch_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL target_wait[%0d]: got %b want 0", i, fetch_valid); end
        end
        tick();
        checks++; if (fetch_valid !== 1'b1 || pc_out !== 32'h104 || instruction_out !== memfn(32'h100)) begin errors++; $display("FAIL target_arrive: got %b/%h/%h want 1/104/%h", fetch_valid, pc_out, instruction_out, memfn(32'h100)); end
        ack_mode = 0;
    endtask

    task automatic test_branch_with_ack();
        warm(3);
        branch_taken = 1'b1; branch_addr = 32'h200;
        tick();
        branch_taken = 1'b0;
        checks++; if (fetch_valid !== 1'b0 || pc_out !== 32'd0 || instruction_out !== 32'd0) begin errors++; $display("FAIL brack_flush: got %b/%h/%h want 0/0/0", fetch_valid, pc_out, instruction_out); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin errors++; $display("FAIL brack_addr: got %b/%h want 1/200", mem_req, mem_addr); end
        tick();
        checks++; if (pc_out !== 32'h204 || instruction_out !== memfn(32'h200)) begin errors++; $display("FAIL brack_first: got %h/%h want 204/%h", pc_out, instruction_out, memfn(32'h200)); end
    endtask

    task automatic test_full_freeze_branch();
        warm(2);
        freeze = 1'b1;
        tick();
        tick();
        checks++; if (mem_req !== 1'b0 || fetch_valid !== 1'b1 || pc_out !== 32'd8) begin errors++; $display("FAIL full_state: got %b/%b/%h want 0/1/8", mem_req, fetch_valid, pc_out); end
        branch_taken = 1'b1; branch_addr = 32'h40;
        tick();
        branch_taken = 1'b0;
        checks++; if (fetch_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h40) begin errors++; $display("FAIL full_branch: got %b/%b/%h want 0/1/40", fetch_valid, mem_req, mem_addr); end
        tick();
        checks++; if (pc_out !== 32'h44 || instruction_out !== memfn(32'h40)) begin errors++; $display("FAIL full_resume: got %h/%h want 44/%h", pc_out, instruction_out, memfn(32'h40)); end
        tick();
        checks++; if (mem_req !== 1'b0 || pc_out !== 32'h44) begin errors++; $display("FAIL refill_full: got %b/%h want 0/44", mem_req, pc_out); end
        ack_force = 1'b1;
        tick();
        tick();
        ack_force = 1'b0;
        checks++; if (pc_out !== 32'h44 || mem_req !== 1'b0) begin errors++; $display("FAIL idle_ack_ignored: got %h/%b want 44/0", pc_out, mem_req); end
        freeze = 1'b0;
        tick();
        checks++; if (pc_out !== 32'h48 || instruction_out !== memfn(32'h44)) begin errors++; $display("FAIL full_drain: got %h/%h want 48/%h", pc_out, instruction_out, memfn(32'h44)); end
    endtask

    task automatic test_reset_mid_request();
        warm(7);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h1C) begin errors++; $display("FAIL mid_setup: got %b/%h want 1/1c", mem_req, mem_addr); end
        #2 rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_addr !== 32'd0) begin errors++; $display("FAIL async_req: got %b/%h want 0/0", mem_req, mem_addr); end
        checks++; if (fetch_valid !== 1'b0 || pc_out !== 32'd0 || instruction_out !== 32'd0) begin errors++; $display("FAIL async_out: got %b/%h/%h want 0/0/0", fetch_valid, pc_out, instruction_out); end
        @(negedge clk);
        tick();
        rst = 1'b0;
        wait_cnt = 0;
        ack_force = 1'b1;
        tick();
        ack_force = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== RST_PC || fetch_valid !== 1'b0) begin errors++; $display("FAIL late_ack: got %b/%h/%b want 1/%h/0", mem_req, mem_addr, fetch_valid, RST_PC); end
        tick();
        checks++; if (pc_out !== RST_PC + 32'd4 || instruction_out !== memfn(RST_PC)) begin errors++; $display("FAIL after_reset_fetch: got %h/%h want %h/%h", pc_out, instruction_out, RST_PC + 32'd4, memfn(RST_PC)); end
    endtask

    task automatic test_random();
        logic [31:0] exp_addr;
        int          npop;
        int          shown;
        apply_reset();
        proto_bad = 0;
        ack_mode  = 2;
        for (int i = 0; i < 3000; i++) begin
            freeze       = ($urandom_range(0, 9) < 3);
            branch_taken = ($urandom_range(0, 19) == 0);
            branch_addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h0000_FFFC);
            tick();
        end
        freeze = 1'b0; branch_taken = 1'b0;
        repeat (20) tick();
        exp_addr = RST_PC;
        npop = 0;
        shown = 0;
        foreach (log_q[k]) begin
            if (log_q[k].br) begin
                exp_addr = {log_q[k].a[31:2], 2'b00};
            end else begin
                npop++;
                checks++;
                if (log_q[k].a !== exp_addr + 32'd4 || log_q[k].d !== memfn(exp_addr)) begin
                    errors++;
                    if (shown < 5) $display("FAIL rand_stream[%0d]: got %h/%h want %h/%h", k, log_q[k].a, log_q[k].d, exp_addr + 32'd4, memfn(exp_addr));
                    shown++;
                end
                exp_addr = exp_addr + 32'd4;
            end
        end
        checks++; if (npop < 300) begin errors++; $display("FAIL rand_throughput: got %0d pops want >= 300", npop); end
        checks++; if (proto_bad !== 0) begin errors++; $display("FAIL rand_protocol: got %0d violations want 0", proto_bad); end
        ack_mode = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        ack_mode = 0; lat = 0; wait_cnt = 0; proto_bad = 0; ack_force = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_freeze();
        test_delayed_branch();
        test_branch_with_ack();
        test_full_freeze_branch();
        test_reset_mid_request();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
